// File: rtl/shrimp_regfile_dumper.sv
// Debug reader that walks shrimp_regfile addresses 0..NUM_REGS-1 and streams each byte out.
// Optional trailing XOR checksum byte when SHRIMP_REGDUMP_CHECKSUM_EN is defined.
module shrimp_regfile_dumper #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] reg_r_addr,
  input  logic [DATA_W-1:0] reg_r_val,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CSUM, S_DONE} state_t;
  logic [DATA_W-1:0] r_csum;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;
`endif

  state_t r_state;
  logic   w_last;

  assign w_last = (reg_r_addr == LAST_ADDR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      reg_r_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            reg_r_addr <= '0;
            busy       <= 1'b1;
            r_state    <= S_FETCH;
`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end

        S_FETCH: begin
          out_data  <= reg_r_val;
          out_valid <= 1'b1;
`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          r_csum    <= r_csum ^ reg_r_val;
`else
          out_last  <= w_last;
`endif
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (w_last) begin
`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
              // Checksum byte is presented immediately; r_csum already folds in the last register.
              out_valid <= 1'b1;
              out_data  <= r_csum;
              out_last  <= 1'b1;
              r_state   <= S_CSUM;
`else
              done      <= 1'b1;
              r_state   <= S_DONE;
`endif
            end else begin
              reg_r_addr <= reg_r_addr + ADDR_W'(1);
              r_state    <= S_FETCH;
            end
          end
        end

`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
        S_CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          reg_r_addr <= '0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shrimp_regfile_dumper.sv
// Scoreboard bench for shrimp_regfile_dumper: stimulus pushes expected bytes, a forked monitor
// pops and compares on every accepted stream byte.
module tb_shrimp_regfile_dumper;

  localparam int NR = 16;
`ifdef SHRIMP_REGDUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int NB = NR + (CSUM ? 1 : 0);

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] reg_r_addr;
  logic [7:0] reg_r_val;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  logic [7:0] regs [NR];
  assign reg_r_val = regs[reg_r_addr];

  shrimp_regfile_dumper #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .reg_r_addr(reg_r_addr), .reg_r_val(reg_r_val), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int byte_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_range(input int n);
    for (int i = 0; i < n; i++)
      q.push_back('{d: regs[i], l: (!CSUM && i == NR - 1)});
  endtask

  task automatic push_dump(input logic [7:0] csum_exp);
    push_range(NR);
    if (CSUM) q.push_back('{d: csum_exp, l: 1'b1});
  endtask

  task automatic start_dump();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_valid_in_fetch", out_valid, 0);
  endtask

  task automatic wait_byte(input int a, input string nm);
    int n = 0;
    while (!(out_valid && reg_r_addr == 4'(a)) && n < 200) begin
      cyc(1);
      n++;
    end
    chk(nm, int'(n < 200), 1);
  endtask

  task automatic wait_done_pulse(input string nm);
    int n = 0;
    while (!done && n < 300) begin
      cyc(1);
      n++;
    end
    chk(nm, int'(n < 300), 1);
  endtask

  task automatic finish_dump(input string nm, input int d0, input int b0);
    wait_done_pulse({nm, "_done_timeout"});
    cyc(1);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_done_once"}, done_cnt - d0, 1);
    chk({nm, "_byte_count"}, byte_cnt - b0, NB);
    chk({nm, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, b0;
    logic [7:0] x;

    fork
      forever begin
        @(negedge clock);
        if (reset_n && done) done_cnt++;
        if (reset_n && out_valid && out_ready) begin
          exp_t e;
          byte_cnt++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got data %0d with empty scoreboard", out_data);
          end else begin
            e = q.pop_front();
            chk("stream_data", out_data, e.d);
            chk("stream_last", out_last, e.l);
          end
        end
      end
    join_none

    // Reset held with start asserted
    reset_n = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) regs[i] = 8'(3 * i);
    cyc(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", reg_r_addr, 0);
    start = 1'b0;
    reset_n = 1'b1;
    cyc(4);
    chk("idle_after_release_busy", busy, 0);
    chk("idle_after_release_valid", out_valid, 0);

    // Full dump r[i]=3*i
    x = '0;
    for (int i = 0; i < NR; i++) x ^= regs[i];
    d0 = done_cnt; b0 = byte_cnt;
    push_dump(x);
    start_dump();
    finish_dump("full", d0, b0);

    // Backpressure on byte 4
    d0 = done_cnt; b0 = byte_cnt;
    push_dump(x);
    start_dump();
    wait_byte(4, "bp_reach_timeout");
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("bp_hold_data", out_data, 12);
      chk("bp_hold_addr", reg_r_addr, 4);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    finish_dump("bp", d0, b0);

    // start while busy and during DONE
    d0 = done_cnt; b0 = byte_cnt;
    push_dump(x);
    start_dump();
    wait_byte(7, "busy_start_reach_timeout");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done_pulse("busy_start_done_timeout");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_in_done_busy", busy, 0);
    cyc(4);
    chk("start_in_done_idle_busy", busy, 0);
    chk("start_in_done_idle_valid", out_valid, 0);
    chk("start_ignored_done_once", done_cnt - d0, 1);
    chk("start_ignored_byte_count", byte_cnt - b0, NB);
    chk("start_ignored_sb_empty", q.size(), 0);

    // Reset while byte 9 is valid, then restart
    push_range(9);
    start_dump();
    wait_byte(9, "rst_mid_reach_timeout");
    out_ready = 1'b0;
    chk("rst_mid_byte9", out_data, 27);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid_async", out_valid, 0);
    chk("rst_mid_busy_async", busy, 0);
    chk("rst_mid_sb_empty", q.size(), 0);
    cyc(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    d0 = done_cnt; b0 = byte_cnt;
    push_dump(x);
    start_dump();
    finish_dump("after_rst", d0, b0);

    // r[i]=i: XOR of 0..15 is 0x00
    for (int i = 0; i < NR; i++) regs[i] = 8'(i);
    d0 = done_cnt; b0 = byte_cnt;
    push_dump(8'h00);
    start_dump();
    finish_dump("ident", d0, b0);

    // r0=0xA5, rest 0: checksum 0xA5
    for (int i = 0; i < NR; i++) regs[i] = 8'h00;
    regs[0] = 8'hA5;
    d0 = done_cnt; b0 = byte_cnt;
    push_dump(8'hA5);
    start_dump();
    finish_dump("a5", d0, b0);

    chk("final_sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
